// File: rtl/uart_cmd_regbank.sv
// uart_cmd_regbank: parses ASCII E/W/R command lines into per-channel enable/mode registers and answers over the UART tx handshake
module uart_cmd_regbank #(
    parameter int NUM_CH      = 4,
    parameter int MODE_W      = 8,
    parameter int TIMEOUT_CYC = 96000,
    parameter bit EN_RST      = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rxd_data,
    input  logic                     rxd_flag,
    output logic [7:0]               tx_data,
    output logic                     tx_en,
    input  logic                     tx_done,
    output logic [NUM_CH-1:0]        ch_enable,
    output logic [NUM_CH*MODE_W-1:0] ch_mode,
    output logic                     cmd_valid,
    output logic                     cmd_err,
    output logic                     rx_drop
);
    localparam int HEXD = MODE_W / 4;
    localparam int IW   = $clog2(HEXD + 3);
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [2:0] {IDLE, CH, ARG, EOL, EXEC, RESP_LD, RESP_WT} state_t;
    typedef enum logic [1:0] {C_E, C_W, C_R} cmd_t;
    typedef enum logic [1:0] {K_OK, K_ER, K_RD} kind_t;

    state_t                    state_q, state_d;
    cmd_t                      cmd_q, cmd_d;
    kind_t                     kind_q, kind_d;
    logic [3:0]                ch_q, ch_d;
    logic [MODE_W-1:0]         arg_q, arg_d;
    logic [IW-1:0]             pos_q, pos_d;
    logic                      disc_q, disc_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic [NUM_CH-1:0]         en_q, en_d;
    logic [NUM_CH*MODE_W-1:0]  mode_q, mode_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic                      tx_en_q, tx_en_d;
    logic                      cmd_valid_q, cmd_valid_d;
    logic                      cmd_err_q, cmd_err_d;
    logic                      rx_drop_q, rx_drop_d;

    logic [MODE_W-1:0] sel_mode;
    logic              sel_en, ok, last, busy, err;
    logic [3:0]        nib;
    logic [7:0]        hex_asc, resp_byte, lc;
    logic [4:0]        hx;

    // {valid, value} for an ASCII hex digit
    function automatic logic [4:0] hexv(input logic [7:0] b);
        if (b >= "0" && b <= "9") return {1'b1, b[3:0]};
        if ((b | 8'h20) >= "a" && (b | 8'h20) <= "f") return {1'b1, b[3:0] + 4'd9};
        return 5'd0;
    endfunction

    always_comb begin
        sel_mode = '0;
        sel_en   = 1'b0;
        nib      = 4'd0;
        for (int k = 0; k < NUM_CH; k++)
            if (ch_q == 4'(k)) begin
                sel_mode = mode_q[k*MODE_W +: MODE_W];
                sel_en   = en_q[k];
            end
        for (int d = 0; d < HEXD; d++)
            if (pos_q == IW'(d)) nib = sel_mode[(HEXD-1-d)*4 +: 4];
        hex_asc   = (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};
        ok        = kind_q == K_OK;
        resp_byte = (kind_q == K_RD) ?
                    ((pos_q < IW'(HEXD)) ? hex_asc : (pos_q == IW'(HEXD)) ? {7'h18, sel_en} :
                     (pos_q == IW'(HEXD + 1)) ? CR : LF) :
                    ((pos_q == IW'(0)) ? (ok ? "O" : "E") : (pos_q == IW'(1)) ? (ok ? "K" : "R") :
                     (pos_q == IW'(2)) ? CR : LF);
        last      = pos_q == ((kind_q == K_RD) ? IW'(HEXD + 2) : IW'(3));
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        kind_d      = kind_q;
        ch_d        = ch_q;
        arg_d       = arg_q;
        pos_d       = pos_q;
        disc_d      = disc_q;
        tmo_d       = tmo_q;
        en_d        = en_q;
        mode_d      = mode_q;
        tx_data_d   = tx_data_q;
        tx_en_d     = 1'b0;
        cmd_valid_d = 1'b0;
        cmd_err_d   = 1'b0;
        busy        = state_q inside {EXEC, RESP_LD, RESP_WT};
        rx_drop_d   = busy && rxd_flag;
        hx          = hexv(rxd_data);
        lc          = rxd_data | 8'h20;
        err         = disc_q || {1'b0, ch_q} >= 5'(NUM_CH);
        if (state_q inside {CH, ARG, EOL}) begin
            tmo_d = rxd_flag ? '0 : tmo_q + 1'b1;
            if (!rxd_flag && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                tmo_d   = '0;
            end
        end
        // discard mode is EOL with disc set: everything up to LF is swallowed
        if (rxd_flag && !busy && rxd_data != CR) begin
            case (state_q)
                IDLE: if (rxd_data != LF) begin
                    cmd_d   = (lc == "w") ? C_W : (lc == "r") ? C_R : C_E;
                    disc_d  = !(lc inside {"e", "w", "r"});
                    state_d = (lc inside {"e", "w", "r"}) ? CH : EOL;
                    arg_d   = '0;
                    pos_d   = '0;
                end
                CH: begin
                    ch_d    = hx[3:0];
                    disc_d  = !hx[4];
                    state_d = (rxd_data == LF) ? EXEC : (hx[4] && cmd_q != C_R) ? ARG : EOL;
                end
                ARG: if (rxd_data == LF) begin
                    disc_d  = 1'b1;
                    state_d = EXEC;
                end else if (cmd_q == C_E) begin
                    arg_d   = MODE_W'(rxd_data[0]);
                    disc_d  = !(rxd_data inside {"0", "1"});
                    state_d = EOL;
                end else if (!hx[4]) begin
                    disc_d  = 1'b1;
                    state_d = EOL;
                end else begin
                    arg_d   = (arg_q << 4) | MODE_W'(hx[3:0]);
                    pos_d   = pos_q + 1'b1;
                    state_d = (pos_q == IW'(HEXD - 1)) ? EOL : ARG;
                end
                EOL: begin
                    disc_d  = disc_q || rxd_data != LF;
                    state_d = (rxd_data == LF) ? EXEC : EOL;
                end
                default: ;
            endcase
        end
        if (state_q == EXEC) begin
            cmd_err_d   = err;
            cmd_valid_d = !err;
            kind_d      = err ? K_ER : (cmd_q == C_R) ? K_RD : K_OK;
            for (int k = 0; k < NUM_CH; k++)
                if (!err && ch_q == 4'(k)) begin
                    if (cmd_q == C_E) en_d[k] = arg_q[0];
                    if (cmd_q == C_W) mode_d[k*MODE_W +: MODE_W] = arg_q;
                end
            pos_d   = '0;
            state_d = RESP_LD;
        end
        if (state_q == RESP_LD) begin
            tx_en_d   = 1'b1;
            tx_data_d = resp_byte;
            state_d   = RESP_WT;
        end
        if (state_q == RESP_WT && tx_done) begin
            state_d = last ? IDLE : RESP_LD;
            pos_d   = pos_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= C_E;
            kind_q      <= K_OK;
            ch_q        <= '0;
            arg_q       <= '0;
            pos_q       <= '0;
            disc_q      <= 1'b0;
            tmo_q       <= '0;
            en_q        <= {NUM_CH{EN_RST}};
            mode_q      <= '0;
            tx_data_q   <= '0;
            tx_en_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            rx_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            kind_q      <= kind_d;
            ch_q        <= ch_d;
            arg_q       <= arg_d;
            pos_q       <= pos_d;
            disc_q      <= disc_d;
            tmo_q       <= tmo_d;
            en_q        <= en_d;
            mode_q      <= mode_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
            rx_drop_q   <= rx_drop_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_en     = tx_en_q;
    assign ch_enable = en_q;
    assign ch_mode   = mode_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_err   = cmd_err_q;
    assign rx_drop   = rx_drop_q;
endmodule
